// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - run-control state encoding and pipeline control bundle
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  localparam int DEFAULT_CNT_SIZE = 32;

  typedef struct packed {
    logic pc_enable;
    logic if_id_enable;
    logic if_id_flush;
    logic id_ex_enable;
    logic id_ex_flush;
    logic ex_mem_enable;
    logic mem_wb_enable;
  } pipe_ctrl_t;

  function automatic logic is_advancing(seq_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - debug/hazard inputs and pipeline controls; PIPE_CYCLE_COUNTER_EN adds o_cycle_count
interface pipeline_sequencer_if
`ifdef PIPE_CYCLE_COUNTER_EN
  #(parameter int CNT_SIZE = pipeline_sequencer_pkg::DEFAULT_CNT_SIZE)
`endif
  ;

  logic i_start;
  logic i_step;
  logic i_load_use;
  logic i_jmp_taken;
  logic i_halt_wb;
  logic o_pc_enable;
  logic o_if_id_enable;
  logic o_if_id_flush;
  logic o_id_ex_enable;
  logic o_id_ex_flush;
  logic o_ex_mem_enable;
  logic o_mem_wb_enable;
  logic o_running;
  logic o_halted;
`ifdef PIPE_CYCLE_COUNTER_EN
  logic [CNT_SIZE-1:0] o_cycle_count;
`endif

  modport master (
    output i_start, i_step, i_load_use, i_jmp_taken, i_halt_wb,
    input  o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_enable,
           o_id_ex_flush, o_ex_mem_enable, o_mem_wb_enable, o_running, o_halted
`ifdef PIPE_CYCLE_COUNTER_EN
    , input o_cycle_count
`endif
  );

  modport slave (
    input  i_start, i_step, i_load_use, i_jmp_taken, i_halt_wb,
    output o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_enable,
           o_id_ex_flush, o_ex_mem_enable, o_mem_wb_enable, o_running, o_halted
`ifdef PIPE_CYCLE_COUNTER_EN
    , output o_cycle_count
`endif
  );

endinterface

// File: rtl/pipeline_sequencer_stall_flush_decoder.sv
// rtl/pipeline_sequencer_stall_flush_decoder.sv - maps advance/load-use/jump onto pipeline enables and flushes
module pipeline_sequencer_stall_flush_decoder
  import pipeline_sequencer_pkg::*;
(
  input  logic       advance,
  input  logic       load_use,
  input  logic       jmp_taken,
  output pipe_ctrl_t ctrl
);

  always_comb begin
    ctrl = '0;
    if (advance) begin
      ctrl.pc_enable     = 1'b1;
      ctrl.if_id_enable  = 1'b1;
      ctrl.id_ex_enable  = 1'b1;
      ctrl.ex_mem_enable = 1'b1;
      ctrl.mem_wb_enable = 1'b1;
      // Load-use holds PC and IF/ID so a coincident jump is seen again next cycle.
      if (load_use) begin
        ctrl.pc_enable    = 1'b0;
        ctrl.if_id_enable = 1'b0;
        ctrl.id_ex_flush  = 1'b1;
      end else if (jmp_taken) begin
        ctrl.if_id_flush = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - pipeline run-control FSM; PIPE_CYCLE_COUNTER_EN enables the advancing-cycle counter
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  pipeline_sequencer_if.slave bus
);

  seq_state_t state;
  seq_state_t next_state;
  logic       advance;
  logic       running_q;
  logic       halted_q;
  pipe_ctrl_t ctrl;

  // Reset kills the enables in the same cycle, before the state register clears.
  assign advance = is_advancing(state) && !i_reset;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.i_start)     next_state = ST_RUN;
        else if (bus.i_step) next_state = ST_STEP;
      end
      ST_RUN:    if (bus.i_halt_wb) next_state = ST_HALTED;
      ST_STEP:   next_state = bus.i_halt_wb ? ST_HALTED : ST_IDLE;
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= next_state;
      running_q <= is_advancing(next_state);
      halted_q  <= (next_state == ST_HALTED);
    end
  end

  pipeline_sequencer_stall_flush_decoder u_decoder (
    .advance   (advance),
    .load_use  (bus.i_load_use),
    .jmp_taken (bus.i_jmp_taken),
    .ctrl      (ctrl)
  );

  assign bus.o_pc_enable     = ctrl.pc_enable;
  assign bus.o_if_id_enable  = ctrl.if_id_enable;
  assign bus.o_if_id_flush   = ctrl.if_id_flush;
  assign bus.o_id_ex_enable  = ctrl.id_ex_enable;
  assign bus.o_id_ex_flush   = ctrl.id_ex_flush;
  assign bus.o_ex_mem_enable = ctrl.ex_mem_enable;
  assign bus.o_mem_wb_enable = ctrl.mem_wb_enable;
  assign bus.o_running       = running_q;
  assign bus.o_halted        = halted_q;

`ifdef PIPE_CYCLE_COUNTER_EN
  logic [$bits(bus.o_cycle_count)-1:0] cycle_count;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      cycle_count <= '0;
    else if (advance)
      cycle_count <= cycle_count + {{($bits(cycle_count)-1){1'b0}}, 1'b1};
  end

  assign bus.o_cycle_count = cycle_count;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - randomized self-checking bench for pipeline_sequencer against a run-control model
module tb_pipeline_sequencer;

  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  pipeline_sequencer_if bus ();

  pipeline_sequencer dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int cmp_count = 0;
  int err_count = 0;

  // Model: 0 idle, 1 continuous run, 2 single step, 3 halted.
  int          m_mode = 0;
  logic [31:0] m_count = '0;

  logic [8:0] obs;
  assign obs = {bus.o_pc_enable, bus.o_if_id_enable, bus.o_if_id_flush, bus.o_id_ex_enable,
                bus.o_id_ex_flush, bus.o_ex_mem_enable, bus.o_mem_wb_enable,
                bus.o_running, bus.o_halted};

  function automatic logic [8:0] exp_outs();
    logic [8:0] e;
    logic adv, lu, j;
    adv = (m_mode == 1 || m_mode == 2) && !i_reset;
    lu  = bus.i_load_use;
    j   = bus.i_jmp_taken;
    e   = '0;
    if (adv) e[8:2] = {!lu, !lu, j && !lu, 1'b1, lu, 1'b1, 1'b1};
    e[1] = (m_mode == 1 || m_mode == 2);
    e[0] = (m_mode == 3);
    return e;
  endfunction

  task automatic cyc(input logic s, input logic st, input logic lu, input logic j,
                     input logic h, input logic r);
    bus.i_start     = s;
    bus.i_step      = st;
    bus.i_load_use  = lu;
    bus.i_jmp_taken = j;
    bus.i_halt_wb   = h;
    i_reset         = r;
    #4;
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_reset) begin
      m_mode  = 0;
      m_count = '0;
    end else if (m_mode == 0) begin
      if (bus.i_start)     m_mode = 1;
      else if (bus.i_step) m_mode = 2;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_count = m_count + 1;
      if (bus.i_halt_wb)    m_mode = 3;
      else if (m_mode == 2) m_mode = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 0, 1, 1, 0, 1);
    cmp_count++;
    if (obs[8:2] !== 7'b0) begin
      err_count++;
      $display("FAIL reset_cycle_ctrl got %b want 0000000", obs[8:2]);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      cmp_count++;
      if (obs !== 9'b0) begin
        err_count++;
        $display("FAIL idle_outputs[%0d] got %b want 000000000", i, obs);
      end
`ifdef PIPE_CYCLE_COUNTER_EN
      cmp_count++;
      if (bus.o_cycle_count !== 32'd0) begin
        err_count++;
        $display("FAIL idle_count got %0d want 0", bus.o_cycle_count);
      end
`endif
      tick();
    end
  endtask

  task automatic test_run_free();
    cyc(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      cmp_count++;
      if (obs !== 9'b110101110) begin
        err_count++;
        $display("FAIL run_free[%0d] got %b want 110101110", i, obs);
      end
      tick();
    end
`ifdef PIPE_CYCLE_COUNTER_EN
    cmp_count++;
    if (bus.o_cycle_count !== 32'd10) begin
      err_count++;
      $display("FAIL run_free_count got %0d want 10", bus.o_cycle_count);
    end
`endif
  endtask

  task automatic test_load_use_jump();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, (i == 0), 0, 0);
      cmp_count++;
      if (obs !== 9'b000111110) begin
        err_count++;
        $display("FAIL load_use_jmp[%0d] got %b want 000111110", i, obs);
      end
      tick();
    end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, (i == 0), 0, 0);
      cmp_count++;
      if (obs !== exp_outs()) begin
        err_count++;
        $display("FAIL jump[%0d] got %b want %b", i, obs, exp_outs());
      end
      tick();
    end
  endtask

  task automatic test_random_run();
    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 0, 0);
      cmp_count++;
      if (obs !== exp_outs()) begin
        err_count++;
        $display("FAIL random_run[%0d] got %b want %b", i, obs, exp_outs());
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    cyc(0, 0, 0, 0, 1, 0);
    cmp_count++;
    if (obs !== 9'b110101110) begin
      err_count++;
      $display("FAIL halt_commit got %b want 110101110", obs);
    end
    tick();
    frozen = m_count;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      cmp_count++;
      if (obs !== 9'b000000001) begin
        err_count++;
        $display("FAIL halted[%0d] got %b want 000000001", i, obs);
      end
`ifdef PIPE_CYCLE_COUNTER_EN
      cmp_count++;
      if (bus.o_cycle_count !== frozen) begin
        err_count++;
        $display("FAIL halted_count got %0d want %0d", bus.o_cycle_count, frozen);
      end
`endif
      tick();
    end
    cyc(0, 0, 0, 0, 0, 1);
    tick();
    cyc(0, 0, 0, 0, 0, 0);
    cmp_count++;
    if (obs !== 9'b0) begin
      err_count++;
      $display("FAIL halt_reset_idle got %b want 000000000", obs);
    end
    tick();
  endtask

  task automatic test_step();
    cyc(0, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      cmp_count++;
      if (obs !== ((i == 0) ? 9'b110101110 : 9'b000000000)) begin
        err_count++;
        $display("FAIL step_pulse[%0d] got %b want %b", i, obs, (i == 0) ? 9'b110101110 : 9'b0);
      end
      tick();
    end
`ifdef PIPE_CYCLE_COUNTER_EN
    cmp_count++;
    if (bus.o_cycle_count !== 32'd1) begin
      err_count++;
      $display("FAIL step_count got %0d want 1", bus.o_cycle_count);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      cmp_count++;
      if (obs !== exp_outs() || obs[1] !== i[0]) begin
        err_count++;
        $display("FAIL held_step[%0d] got %b want %b", i, obs, exp_outs());
      end
      tick();
    end
  endtask

  task automatic test_start_step();
    cyc(0, 0, 0, 0, 0, 0);
    tick();
    cyc(1, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      cmp_count++;
      if (obs !== 9'b110101110) begin
        err_count++;
        $display("FAIL start_step_run[%0d] got %b want 110101110", i, obs);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    cyc(0, 0, 0, 0, 0, 1);
    cmp_count++;
    if (obs !== 9'b000000010) begin
      err_count++;
      $display("FAIL reset_mid_run got %b want 000000010", obs);
    end
    tick();
    cyc(0, 0, 0, 0, 0, 0);
    cmp_count++;
    if (obs !== 9'b0) begin
      err_count++;
      $display("FAIL after_reset got %b want 000000000", obs);
    end
`ifdef PIPE_CYCLE_COUNTER_EN
    cmp_count++;
    if (bus.o_cycle_count !== 32'd0) begin
      err_count++;
      $display("FAIL after_reset_count got %0d want 0", bus.o_cycle_count);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 14) == 0),
          (m_mode == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0));
      cmp_count++;
      if (obs !== exp_outs()) begin
        err_count++;
        $display("FAIL random[%0d] got %b want %b", i, obs, exp_outs());
      end
`ifdef PIPE_CYCLE_COUNTER_EN
      cmp_count++;
      if (bus.o_cycle_count !== m_count) begin
        err_count++;
        $display("FAIL random_count[%0d] got %0d want %0d", i, bus.o_cycle_count, m_count);
      end
`endif
      tick();
    end
  endtask

  initial begin
    i_reset         = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_step      = 1'b0;
    bus.i_load_use  = 1'b0;
    bus.i_jmp_taken = 1'b0;
    bus.i_halt_wb   = 1'b0;
    @(posedge i_clk);
    #1;
    test_reset();
    test_run_free();
    test_load_use_jump();
    test_jump();
    test_random_run();
    test_halt();
    test_step();
    test_start_step();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
